// File: rtl/alu_seq.sv
// Multi-cycle ALU: single-cycle shift/logic/add/btr/passB plus iterative shift-add MUL
// and restoring DIV behind a start/done handshake; Hi carries product high / remainder.
module alu_seq #(
    parameter int WIDTH   = 16,
    parameter int SHAMT_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [3:0]         Oper,
    input  logic [WIDTH-1:0]   InA,
    input  logic [WIDTH-1:0]   InB,
    input  logic               Cin,
    input  logic               invA,
    input  logic               invB,
    input  logic               sign,
    output logic               busy,
    output logic               done,
    output logic [WIDTH-1:0]   Out,
    output logic [WIDTH-1:0]   Hi,
    output logic               Zero,
    output logic               Ofl,
    output logic               CF,
    output logic               DivZero
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ITER = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;

    localparam logic [3:0] OP_ROL   = 4'b0000;
    localparam logic [3:0] OP_SLL   = 4'b0001;
    localparam logic [3:0] OP_SRA   = 4'b0010;
    localparam logic [3:0] OP_SRL   = 4'b0011;
    localparam logic [3:0] OP_ADD   = 4'b0100;
    localparam logic [3:0] OP_AND   = 4'b0101;
    localparam logic [3:0] OP_OR    = 4'b0110;
    localparam logic [3:0] OP_XOR   = 4'b0111;
    localparam logic [3:0] OP_BTR   = 4'b1000;
    localparam logic [3:0] OP_PASSB = 4'b1001;
    localparam logic [3:0] OP_MUL   = 4'b1010;
    localparam logic [3:0] OP_DIV   = 4'b1011;

    localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

    logic [1:0]         state;
    logic [SHAMT_W-1:0] cnt;
    logic               is_mul_r;
    logic               sign_r;
    logic               neg_q;
    logic               neg_r;
    logic               min_case;
    logic [WIDTH-1:0]   acc_hi;     // MUL: running product high / DIV: partial remainder
    logic [WIDTH-1:0]   acc_lo;     // MUL: multiplier shifting out / DIV: quotient shifting in
    logic [WIDTH-1:0]   mcand;      // multiplicand or divisor magnitude

    logic [WIDTH-1:0]   a_eff;
    logic [WIDTH-1:0]   b_eff;
    logic [SHAMT_W-1:0] shamt;
    logic [SHAMT_W:0]   rot_r;
    logic [WIDTH:0]     sum_ext;
    logic [WIDTH-1:0]   btr_a;
    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;
    logic               is_multi;

    assign a_eff    = invA ? ~InA : InA;
    assign b_eff    = invB ? ~InB : InB;
    assign shamt    = b_eff[SHAMT_W-1:0];
    assign rot_r    = (SHAMT_W+1)'(WIDTH) - {1'b0, shamt};
    assign sum_ext  = {1'b0, a_eff} + {1'b0, b_eff} + {{WIDTH{1'b0}}, Cin};
    assign mag_a    = (sign && a_eff[WIDTH-1]) ? -a_eff : a_eff;
    assign mag_b    = (sign && b_eff[WIDTH-1]) ? -b_eff : b_eff;
    assign is_multi = (Oper == OP_MUL) || ((Oper == OP_DIV) && (b_eff != '0));
    assign busy     = (state != S_IDLE);

    always_comb begin
        for (int i = 0; i < WIDTH; i++) begin
            btr_a[i] = InA[WIDTH-1-i];
        end
    end

    logic [WIDTH-1:0] sc_out;
    logic [WIDTH-1:0] sc_hi;
    logic             sc_ofl;
    logic             sc_cf;
    logic             sc_dz;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        sc_out = '0;
        sc_hi  = '0;
        sc_ofl = 1'b0;
        sc_cf  = 1'b0;
        sc_dz  = 1'b0;
        case (Oper)
            OP_ROL:   sc_out = (a_eff << shamt) | (a_eff >> rot_r);
            OP_SLL:   sc_out = a_eff << shamt;
            OP_SRA:   sc_out = $unsigned($signed(a_eff) >>> shamt);
            OP_SRL:   sc_out = a_eff >> shamt;
            OP_ADD: begin
                sc_out = sum_ext[WIDTH-1:0];
                sc_cf  = sum_ext[WIDTH];
                sc_ofl = sign ? ((a_eff[WIDTH-1] == b_eff[WIDTH-1]) &&
                                 (sum_ext[WIDTH-1] != a_eff[WIDTH-1]))
                              : sum_ext[WIDTH];
            end
            OP_AND:   sc_out = a_eff & b_eff;
            OP_OR:    sc_out = a_eff | b_eff;
            OP_XOR:   sc_out = a_eff ^ b_eff;
            OP_BTR:   sc_out = btr_a;
            OP_PASSB: sc_out = InB;
            OP_MUL:   sc_out = '0;
            OP_DIV: begin
                // only reached here as a single-cycle op when dividing by zero
                sc_out = '1;
                sc_hi  = a_eff;
                sc_dz  = 1'b1;
            end
            default:  sc_ofl = 1'b1;
        endcase
    end

    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     rem_sh;
    logic [WIDTH:0]     diff;
    logic [WIDTH-1:0]   it_hi;
    logic [WIDTH-1:0]   it_lo;

    always_comb begin
        mul_sum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, mcand} : '0);
        rem_sh  = {acc_hi, acc_lo[WIDTH-1]};
        diff    = rem_sh - {1'b0, mcand};
        if (is_mul_r) begin
            it_hi = mul_sum[WIDTH:1];
            it_lo = {mul_sum[0], acc_lo[WIDTH-1:1]};
        end else if (!diff[WIDTH]) begin
            it_hi = diff[WIDTH-1:0];
            it_lo = {acc_lo[WIDTH-2:0], 1'b1};
        end else begin
            it_hi = rem_sh[WIDTH-1:0];
            it_lo = {acc_lo[WIDTH-2:0], 1'b0};
        end
    end

    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   fx_out;
    logic [WIDTH-1:0]   fx_hi;
    logic               fx_ofl;

    always_comb begin
        prod = neg_q ? -{acc_hi, acc_lo} : {acc_hi, acc_lo};
        if (is_mul_r) begin
            fx_out = prod[WIDTH-1:0];
            fx_hi  = prod[2*WIDTH-1:WIDTH];
            fx_ofl = sign_r ? (fx_hi != {WIDTH{fx_out[WIDTH-1]}}) : (fx_hi != '0);
        end else begin
            fx_out = neg_q ? -acc_lo : acc_lo;
            fx_hi  = neg_r ? -acc_hi : acc_hi;
            fx_ofl = min_case;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            cnt      <= '0;
            is_mul_r <= 1'b0;
            sign_r   <= 1'b0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            min_case <= 1'b0;
            acc_hi   <= '0;
            acc_lo   <= '0;
            mcand    <= '0;
            done     <= 1'b0;
            Out      <= '0;
            Hi       <= '0;
            Zero     <= 1'b0;
            Ofl      <= 1'b0;
            CF       <= 1'b0;
            DivZero  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start && is_multi) begin
                        state    <= S_ITER;
                        cnt      <= SHAMT_W'(WIDTH - 1);
                        is_mul_r <= (Oper == OP_MUL);
                        sign_r   <= sign;
                        neg_q    <= sign && (a_eff[WIDTH-1] ^ b_eff[WIDTH-1]);
                        neg_r    <= sign && a_eff[WIDTH-1];
                        min_case <= sign && (Oper == OP_DIV) &&
                                    (a_eff == MIN_VAL) && (b_eff == '1);
                        acc_hi   <= '0;
                        acc_lo   <= mag_a;
                        mcand    <= mag_b;
                    end else if (start) begin
                        done    <= 1'b1;
                        Out     <= sc_out;
                        Hi      <= sc_hi;
                        Zero    <= (sc_out == '0);
                        Ofl     <= sc_ofl;
                        CF      <= sc_cf;
                        DivZero <= sc_dz;
                    end
                end
                S_ITER: begin
                    acc_hi <= it_hi;
                    acc_lo <= it_lo;
                    cnt    <= cnt - 1'b1;
                    if (cnt == '0) state <= S_FIX;
                end
                S_FIX: begin
                    state   <= S_IDLE;
                    done    <= 1'b1;
                    Out     <= fx_out;
                    Hi      <= fx_hi;
                    Zero    <= (fx_out == '0);
                    Ofl     <= fx_ofl;
                    CF      <= 1'b0;
                    DivZero <= 1'b0;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
